// File: rtl/hpi_bus_phy_pkg.sv
// Shared definitions for the HPI physical-layer strobe sequencer:
// register addresses, FSM encoding and phase-counter width.
package hpi_bus_phy_pkg;

   localparam int CNT_W = 4;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4
   } phy_state_e;

   function automatic logic [CNT_W-1:0] cyc_to_cnt(input int unsigned cyc);
      return cyc[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/hpi_bus_phy_irq_sync.sv
// Two-flop synchroniser for the asynchronous HPI INT pin plus a third
// flop that provides the rising-edge pulse.
module hpi_bus_phy_irq_sync (
   input  logic clk,
   input  logic resetn,
   input  logic irq_async,
   output logic irq_level,
   output logic irq_rise
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // synchroniser chain and edge-history flop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
         prev_r <= 1'b0;
      end else begin
         meta_r <= irq_async;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign irq_level = sync_r;
   assign irq_rise  = sync_r & ~prev_r;

endmodule

// File: rtl/hpi_bus_phy.sv
// CY7C67300 HPI strobe sequencer: turns one upstream word request into a
// timed nCS/nRD/nWR cycle, returns read data and a completion pulse.
module hpi_bus_phy
   import hpi_bus_phy_pkg::*;
#(
   parameter int unsigned SETUP_CYC    = 1,
   parameter int unsigned STROBE_CYC   = 3,
   parameter int unsigned HOLD_CYC     = 1,
   parameter int unsigned RECOVERY_CYC = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic        irq_level,
   output logic        irq_rise,
   output logic        hpi_csn,
   output logic        hpi_oen,
   output logic        hpi_wen,
   output logic [1:0]  hpi_address,
   inout  wire  [15:0] hpi_data,
   input  logic        hpi_irq
);

   localparam logic [CNT_W-1:0] SETUP_L    = cyc_to_cnt(SETUP_CYC);
   localparam logic [CNT_W-1:0] STROBE_L   = cyc_to_cnt(STROBE_CYC);
   localparam logic [CNT_W-1:0] HOLD_L     = cyc_to_cnt(HOLD_CYC);
   localparam logic [CNT_W-1:0] RECOVERY_L = cyc_to_cnt(RECOVERY_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE    = cyc_to_cnt(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = cyc_to_cnt(32'd0);

   phy_state_e       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             write_r;
   logic [15:0]      wdata_r;
   logic             drive_r;
   logic             req_ready_r;
   logic             rsp_valid_r;
   logic [15:0]      rdata_r;
   logic             busy_r;
   logic             csn_r;
   logic             oen_r;
   logic             wen_r;
   logic [1:0]       addr_r;

   // phase sequencer; every pin comes straight from a flop so nothing glitches
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         write_r     <= 1'b0;
         wdata_r     <= 16'h0000;
         drive_r     <= 1'b0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rdata_r     <= 16'h0000;
         busy_r      <= 1'b0;
         csn_r       <= 1'b1;
         oen_r       <= 1'b1;
         wen_r       <= 1'b1;
         addr_r      <= HPI_DATA;
      end else begin
         rsp_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready_r) begin
                  state_r     <= ST_SETUP;
                  cnt_r       <= SETUP_L;
                  write_r     <= req_write;
                  wdata_r     <= req_wdata;
                  addr_r      <= req_addr;
                  drive_r     <= req_write;
                  csn_r       <= 1'b0;
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_STROBE;
                  cnt_r   <= STROBE_L;
                  if (write_r) begin
                     wen_r <= 1'b0;
                  end else begin
                     oen_r <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_STROBE: begin
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_HOLD;
                  cnt_r   <= HOLD_L;
                  oen_r   <= 1'b1;
                  wen_r   <= 1'b1;
                  if (!write_r) begin
                     rdata_r <= hpi_data;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_HOLD: begin
               if (cnt_r == CNT_ONE) begin
                  state_r     <= ST_RECOVER;
                  cnt_r       <= RECOVERY_L;
                  csn_r       <= 1'b1;
                  drive_r     <= 1'b0;
                  rsp_valid_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_RECOVER: begin
               if (cnt_r == CNT_ONE) begin
                  state_r     <= ST_IDLE;
                  cnt_r       <= CNT_ZERO;
                  req_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               // an illegal encoding parks the bus in its safe idle state
               state_r     <= ST_IDLE;
               cnt_r       <= CNT_ZERO;
               drive_r     <= 1'b0;
               csn_r       <= 1'b1;
               oen_r       <= 1'b1;
               wen_r       <= 1'b1;
               req_ready_r <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign hpi_data    = drive_r ? wdata_r : 16'hzzzz;
   assign req_ready   = req_ready_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_rdata   = rdata_r;
   assign busy        = busy_r;
   assign hpi_csn     = csn_r;
   assign hpi_oen     = oen_r;
   assign hpi_wen     = wen_r;
   assign hpi_address = addr_r;

   hpi_bus_phy_irq_sync u_irq_sync (
      .clk       (clk),
      .resetn    (resetn),
      .irq_async (hpi_irq),
      .irq_level (irq_level),
      .irq_rise  (irq_rise)
   );

endmodule
